iir_dac_tx: RTL and testbench

Output-side serial transmitter for the IIR filter chain: it accepts signed 12-bit filtered samples from the cascade output, buffers them in a small FIFO and shifts each one out as a 16-bit frame on a three-wire DAC interface (sclk, sync_n, sdo). It sits between the filter's `dout` and the board DAC, running on the same system clock with its own sclk divider. Flow control is a valid/ready handshake plus a sticky overflow flag for samples offered while the FIFO is full.

---
 rtl/iir_dac_tx.sv | 99 +++++++++
 tb/tb_iir_dac_tx.sv | 118 +++++++++++
 2 files changed

// File: rtl/iir_dac_tx.sv
// iir_dac_tx: sample FIFO plus 16-bit {CMD,data} serial frame transmitter for the DAC.
// Define IIR_DAC_OFFSET_BIN_EN to send the data field as offset binary.
module iir_dac_tx #(
   parameter int CLK_DIV = 4,
   parameter int FIFO_DEPTH = 4,
   parameter logic [3:0] CMD = 4'b0011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic        sclk,
   output logic        sync_n,
   output logic        sdo,
   output logic        busy,
   output logic        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = $clog2(2 * CLK_DIV);
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
   state_t state;
   logic [11:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] count;
   logic [15:0] sh;
   logic [DW-1:0] div;
   logic [3:0] bitn;
   logic push, pop, last;
   logic [11:0] head;
   assign din_ready = count != CW'(FIFO_DEPTH);
   assign push = din_valid && din_ready;
   assign last = div == DW'(2 * CLK_DIV - 1);
   assign pop = count != '0 && (state == IDLE || (state == GAP && last));
   assign busy = state != IDLE || count != '0;
`ifdef IIR_DAC_OFFSET_BIN_EN
   assign head = {~mem[rp][11], mem[rp][10:0]};
`else
   assign head = mem[rp];
`endif
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         count <= count + CW'(push) - CW'(pop);
         if (din_valid && !din_ready) overflow <= 1'b1;
      end
   end
   // div counts the 2*CLK_DIV cycles of one sclk period, and the inter-frame gap
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sclk <= 1'b0;
         sync_n <= 1'b1;
         sdo <= 1'b0;
         sh <= '0;
         div <= '0;
         bitn <= '0;
      end else if (pop) begin
         state <= SHIFT;
         sh <= {CMD, head};
         sdo <= CMD[3];
         sync_n <= 1'b0;
         sclk <= 1'b0;
         div <= '0;
         bitn <= '0;
      end else if (state == SHIFT) begin
         if (div == DW'(CLK_DIV - 1)) begin
            sclk <= 1'b1;
            div <= div + 1'b1;
         end else if (last) begin
            div <= '0;
            sclk <= 1'b0;
            if (bitn == 4'd15) begin
               state <= GAP;
               sync_n <= 1'b1;
               sdo <= 1'b0;
            end else begin
               bitn <= bitn + 1'b1;
               sh <= sh << 1;
               sdo <= sh[14];
            end
         end else begin
            div <= div + 1'b1;
         end
      end else if (state == GAP) begin
         div <= last ? '0 : div + 1'b1;
         if (last) state <= IDLE;
      end
   end
endmodule

// File: tb/tb_iir_dac_tx.sv
// tb_iir_dac_tx: random and directed traffic checked cycle by cycle against a frame-schedule model.
module tb_iir_dac_tx;
   localparam int CD = 4;
   localparam int DEPTH = 4;
   logic clk = 1'b0;
   logic rst, din_valid;
   logic [11:0] din;
   logic din_ready, sclk, sync_n, sdo, busy, overflow;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   iir_dac_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .CMD(4'b0011)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .sclk(sclk), .sync_n(sync_n), .sdo(sdo), .busy(busy), .overflow(overflow)
   );
   typedef struct {int start; logic [15:0] w;} ent_t;
   ent_t pend[$];
   int n = 0, last_start = -100000, nbits = 0;
   logic [15:0] cur_w = '0, cap = '0, fw = '0;
   logic ovf = 1'b0, psclk = 1'b0, psync = 1'b1;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
      end
   endtask
   function automatic logic [15:0] word(input logic [11:0] d);
`ifdef IIR_DAC_OFFSET_BIN_EN
      return {4'b0011, ~d[11], d[10:0]};
`else
      return {4'b0011, d};
`endif
   endfunction
   // Each accepted sample starts a frame one cycle after acceptance, but no sooner
   // than one full frame period (34*CD) after the previous frame started.
   task automatic step(input logic r, input logic v, input logic [11:0] d);
      int rel, prev, st;
      logic xr;
      xr = pend.size() != DEPTH;
      rst = r;
      din_valid = v;
      din = d;
      @(posedge clk);
      n++;
      if (r) begin
         pend.delete();
         last_start = -100000;
         ovf = 1'b0;
      end else begin
         if (v && !xr) ovf = 1'b1;
         if (v && xr) begin
            prev = pend.size() != 0 ? pend[$].start : last_start;
            st = (n + 1 > prev + 34 * CD) ? n + 1 : prev + 34 * CD;
            pend.push_back('{st, word(d)});
         end
         if (pend.size() != 0 && pend[0].start == n) begin
            cur_w = pend[0].w;
            last_start = n;
            void'(pend.pop_front());
         end
      end
      #1;
      rel = n - last_start;
      check("sync_n", sync_n, !(rel >= 0 && rel < 32 * CD));
      check("sclk", sclk, rel >= 0 && rel < 32 * CD && (rel % (2 * CD)) >= CD);
      check("sdo", sdo, (rel >= 0 && rel < 32 * CD) ? cur_w[15 - rel / (2 * CD)] : 1'b0);
      check("busy", busy, pend.size() != 0 || (rel >= 0 && rel < 34 * CD));
      check("din_ready", din_ready, pend.size() != DEPTH);
      check("overflow", overflow, ovf);
      if (psync && !sync_n) begin
         nbits = 0;
         cap = '0;
         fw = cur_w;
      end
      if (!sync_n && !psclk && sclk) begin
         cap = {cap[14:0], sdo};
         nbits++;
      end
      if (!psync && sync_n && !r) begin
         check("frame_word", cap, fw);
         check("frame_bits", nbits, 16);
      end
      psync = sync_n;
      psclk = sclk;
   endtask
   initial begin
      logic [11:0] dirv [3];
      int g;
      dirv = '{12'hFFF, 12'h800, 12'h000};
      repeat (3) step(1'b1, 1'($urandom), 12'($urandom));
      step(1'b0, 1'b1, 12'h5A3);
      repeat (140) step(1'b0, 1'b0, 12'h000);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, dirv[i]);
         repeat (140) step(1'b0, 1'b0, 12'h000);
      end
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 12'(i * 12'h111 + 12'h0A5));
      repeat (5 * 140) step(1'b0, 1'b0, 12'h000);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 12'($urandom));
         repeat (140) step(1'b0, 1'b0, 12'h000);
      end
      step(1'b1, 1'b0, 12'h000);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12'($urandom));
      g = 0;
      while (n - last_start < 17 * CD + 1 && g < 200) begin
         step(1'b0, 1'b0, 12'h000);
         g++;
      end
      step(1'b1, 1'b0, 12'h000);
      repeat (200) step(1'b0, 1'b0, 12'h000);
      repeat (3000) step($urandom_range(0, 999) == 0, $urandom_range(0, 99) == 0, 12'($urandom));
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 12'($urandom));
      repeat (800) step(1'b0, 1'b0, 12'h000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
